// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions.
// Used by the PC redirect unit and by the condition handler, which shares
// the branch and jump opcode constants.
package pipe_ctrl_pkg;

    // Redirect state machine states.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } redir_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          INSN_BYTES   = 4;

    // RV32 major opcodes for control-transfer instructions.
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;

endpackage

// File: rtl/pc_redirect_unit_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   inc        : count up by one this cycle
//   count      : current value
//   sat        : count is at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    assign sat = &count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          count <= '0;
        else if (inc && !sat) count <= count + W'(1);
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the fetch PC and turns taken branches and jumps
// from EX into PC redirects plus a fixed-length IF/ID and ID/EX flush.
// A redirect that arrives while the hazard unit stalls is parked in
// pend_pc and applied on the first unstalled cycle.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   stall                      : hazard freeze of PC and IF/ID
//   branch_valid/conditional_s : taken conditional branch when both high
//   branch_target              : EX-computed branch target
//   jump_valid/jump_target     : JAL/JALR request and target (wins over branch)
//   pc_out                     : current fetch PC
//   flush_ifid/flush_idex      : squash strobes, high for FLUSH_CYCLES cycles
//   redirect_busy              : redirect pending or flush in progress
//   misalign_err               : accepted target had nonzero bits[1:0]
//   taken_count                : saturating count of applied redirects
module pc_redirect_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_PC     = PC_W'(RESET_PC_DEF),
    parameter int              FLUSH_CYCLES = 2,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_valid,
    input  logic             conditional_s,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             jump_valid,
    input  logic [PC_W-1:0]  jump_target,
    output logic [PC_W-1:0]  pc_out,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             redirect_busy,
    output logic             misalign_err,
    output logic [CNT_W-1:0] taken_count
);

    localparam int FC_W = 3;  // FLUSH_CYCLES is limited to 1..7

    redir_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_q, pend_d;
    logic [FC_W-1:0] cnt_q, cnt_d;
    logic            req, apply, cnt_sat;
    logic [PC_W-1:0] tgt_raw, tgt_al, pc_inc;

    assign req     = (branch_valid & conditional_s) | jump_valid;
    assign tgt_raw = jump_valid ? jump_target : branch_target;
    assign tgt_al  = {tgt_raw[PC_W-1:2], 2'b00};
    assign pc_inc  = pc_q + PC_W'(INSN_BYTES);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Next-state and datapath next values
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        apply   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (req && !stall) begin
                    pc_d    = tgt_al;
                    cnt_d   = FC_W'(FLUSH_CYCLES - 1);
                    apply   = 1'b1;
                    state_d = FLUSH;
                end else if (req) begin
                    pend_d  = tgt_al;
                    state_d = PEND;
                end else if (!stall) begin
                    pc_d = pc_inc;
                end
            end
            // Younger requests are ignored here: the parked one is older.
            PEND: begin
                if (!stall) begin
                    pc_d    = pend_q;
                    cnt_d   = FC_W'(FLUSH_CYCLES - 1);
                    apply   = 1'b1;
                    state_d = FLUSH;
                end
            end
            // Requests here come from squashed instructions. Stall only
            // freezes the PC; the flush length is fixed.
            FLUSH: begin
                if (!stall) pc_d = pc_inc;
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - FC_W'(1);
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs
    always_comb begin
        flush_ifid    = (state_q == FLUSH);
        flush_idex    = (state_q == FLUSH);
        redirect_busy = (state_q != RUN);
        // Only RUN accepts a target; gate with reset so it reads 0 in reset.
        misalign_err  = rst_n && (state_q == RUN) && req && (tgt_raw[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pc_out = pc_q;

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (apply),
        .count (taken_count),
        .sat   (cnt_sat)
    );

    logic unused_ok;
    assign unused_ok = cnt_sat;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit. taken_count is built 2 bits wide so
// saturation is reached after three redirects.
module tb_pc_redirect_unit;

    localparam int PC_W  = 32;
    localparam int CNT_W = 2;

    logic             clk, rst_n, stall;
    logic             branch_valid, conditional_s, jump_valid;
    logic [PC_W-1:0]  branch_target, jump_target, pc_out;
    logic             flush_ifid, flush_idex, redirect_busy, misalign_err;
    logic [CNT_W-1:0] taken_count;

    int errors = 0;
    int checks = 0;

    pc_redirect_unit #(
        .PC_W(PC_W), .RESET_PC(32'h0), .FLUSH_CYCLES(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_valid(branch_valid), .conditional_s(conditional_s),
        .branch_target(branch_target), .jump_valid(jump_valid),
        .jump_target(jump_target), .pc_out(pc_out),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .redirect_busy(redirect_busy), .misalign_err(misalign_err),
        .taken_count(taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        branch_valid = 0; conditional_s = 0; jump_valid = 0; stall = 0;
        branch_target = '0; jump_target = '0;
    endtask

    // pc / flush / busy / count snapshot
    task automatic snap(input string tag, input logic [31:0] pc, input logic fl,
                        input logic busy, input logic [CNT_W-1:0] cnt);
        chk({tag, ".pc"}, 64'(pc_out), 64'(pc));
        chk({tag, ".fifid"}, 64'(flush_ifid), 64'(fl));
        chk({tag, ".fidex"}, 64'(flush_idex), 64'(fl));
        chk({tag, ".busy"}, 64'(redirect_busy), 64'(busy));
        chk({tag, ".cnt"}, 64'(taken_count), 64'(cnt));
    endtask

    initial begin
        idle();
        rst_n = 0;
        #12;
        snap("rst", 32'h0, 0, 0, 0);
        chk("rst.mis", 64'(misalign_err), 64'd0);
        rst_n = 1;

        // free-running fetch
        for (int i = 1; i <= 4; i++) begin
            tick();
            snap("free", 32'(4 * i), 0, 0, 0);
        end

        // taken branch at 0x10
        branch_valid = 1; conditional_s = 1; branch_target = 32'h40;
        #1 chk("br.mis", 64'(misalign_err), 64'd0);
        tick(); idle();
        snap("br0", 32'h40, 1, 1, 1);
        tick(); snap("br1", 32'h44, 1, 1, 1);
        tick(); snap("br2", 32'h48, 0, 0, 1);

        // not-taken branch
        branch_valid = 1; conditional_s = 0; branch_target = 32'h80;
        tick(); idle();
        snap("nt", 32'h4C, 0, 0, 1);

        // jump during a 3-cycle stall
        stall = 1; jump_valid = 1; jump_target = 32'h100;
        tick(); jump_valid = 0; jump_target = '0;
        snap("st0", 32'h4C, 0, 1, 1);
        tick(); snap("st1", 32'h4C, 0, 1, 1);
        tick(); snap("st2", 32'h4C, 0, 1, 1);
        stall = 0;
        tick(); snap("pend", 32'h100, 1, 1, 2);

        // request during flush is ignored, including its misalignment
        branch_valid = 1; conditional_s = 1; branch_target = 32'h203;
        #1 chk("fl.mis", 64'(misalign_err), 64'd0);
        tick(); snap("fl1", 32'h104, 1, 1, 2);
        tick(); idle();
        snap("fl2", 32'h108, 0, 0, 2);

        // misaligned jump
        jump_valid = 1; jump_target = 32'h123;
        #1 chk("mis.pulse", 64'(misalign_err), 64'd1);
        tick(); idle();
        chk("mis.off", 64'(misalign_err), 64'd0);
        snap("mis", 32'h120, 1, 1, 3);
        tick(); tick();
        snap("mis2", 32'h128, 0, 0, 3);

        // saturation, stall inside flush, and wraparound
        jump_valid = 1; jump_target = 32'hFFFF_FFF4;
        tick(); idle();
        snap("sat", 32'hFFFF_FFF4, 1, 1, 3);
        stall = 1;
        tick(); stall = 0;
        snap("flst", 32'hFFFF_FFF4, 1, 1, 3);
        tick(); snap("flst2", 32'hFFFF_FFF8, 0, 0, 3);
        tick(); snap("wrap0", 32'hFFFF_FFFC, 0, 0, 3);
        tick(); snap("wrap1", 32'h0, 0, 0, 3);

        // reset mid-FLUSH
        jump_valid = 1; jump_target = 32'h300;
        tick(); idle();
        snap("prer", 32'h300, 1, 1, 3);
        rst_n = 0;
        #1 snap("rflush", 32'h0, 0, 0, 0);
        #2 rst_n = 1;

        // reset mid-PEND discards the parked target
        tick();
        snap("rel", 32'h4, 0, 0, 0);
        stall = 1; jump_valid = 1; jump_target = 32'h500;
        tick(); idle(); stall = 1;
        snap("pend2", 32'h4, 0, 1, 0);
        rst_n = 0;
        #1 snap("rpend", 32'h0, 0, 0, 0);
        #2 rst_n = 1; stall = 0;
        tick(); snap("rpend2", 32'h4, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Runaway guard
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Owns the program counter and turns the branch decision from the condition handler, plus jump requests, into next-PC selection and pipeline flushes.
- Sits directly downstream of the condition handler (conditional_s) and upstream of the IF stage and the IF/ID and ID/EX pipeline registers.
- Arbitrates redirects against hazard stalls, holds a redirect that arrives during a stall, and drives a fixed-length flush sequence.

Parameters:
- PC_W, 32, PC and target width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles flush_ifid/flush_idex stay high after a redirect is applied (range 1..7).
- CNT_W, 16, width of the taken-redirect performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hazard unit freezes PC and IF/ID.
- branch_valid  input  1  EX stage holds a conditional branch this cycle.
- conditional_s  input  1  condition handler result, qualified by branch_valid.
- branch_target  input  PC_W  EX-computed branch target.
- jump_valid  input  1  EX stage holds JAL/JALR.
- jump_target  input  PC_W  EX-computed jump target.
- pc_out  output  PC_W  current fetch PC.
- flush_ifid  output  1  squash IF/ID contents.
- flush_idex  output  1  squash ID/EX contents.
- redirect_busy  output  1  high in PEND or FLUSH.
- misalign_err  output  1  one-cycle pulse when an accepted target has bits[1:0] != 0.
- taken_count  output  CNT_W  saturating count of applied redirects.

Behaviour:
- Reset (async, rst_n=0): pc_out=RESET_PC, state=RUN, flush_*=0, misalign_err=0, taken_count=0, pending regs=0. Release is synchronous to the next rising clk.
- req = (branch_valid & conditional_s) | jump_valid. A branch target with conditional_s=0 is ignored.
- Target select: jump_target when jump_valid=1, else branch_target. Both valid at once is illegal in the pipeline; jump wins.
- Accepted target is stored with bits[1:0] forced to 0. If the raw bits[1:0] != 0, misalign_err pulses for one cycle in the accept cycle.
- State machine:
  - RUN, req=1, stall=0: pc_out <= target next edge. Enter FLUSH with cnt=FLUSH_CYCLES-1. taken_count++.
  - RUN, req=1, stall=1: latch target into pend_pc. Enter PEND. pc_out holds.
  - RUN, req=0, stall=1: pc_out holds.
  - RUN, req=0, stall=0: pc_out <= pc_out+4, wrapping modulo 2^PC_W.
  - PEND: pc_out holds while stall=1. On the first cycle with stall=0: pc_out <= pend_pc, enter FLUSH, taken_count++. req is ignored in PEND because the issuing instruction is older and already captured.
  - FLUSH: flush_ifid=flush_idex=1 (Moore, registered). pc_out <= pc_out+4 unless stall=1. req is ignored (it comes from squashed instructions). cnt decrements; at cnt=0 with the edge, go to RUN.
- Latency: redirect accepted in cycle N gives pc_out=target and flush high from cycle N+1. Flush lasts exactly FLUSH_CYCLES cycles; stall does not extend it.
- redirect_busy = (state != RUN).
- taken_count saturates at all-ones with no wrap.
- Reset asserted mid-PEND or mid-FLUSH aborts immediately to the reset values. The pending target is discarded.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum {RUN, PEND, FLUSH};
  - the RESET_PC default;
  - the INSN_BYTES=4 constant;
  - the branch/jump opcode constants shared with the condition handler.
- One natural sub-module: sat_counter (parameterised width, inc, sat), used for taken_count.
- The PC register, FSM and flush counter stay in the top module.

Test Plan:
- Reset, then 4 free cycles, no req -> pc_out 0x0, 0x4, 0x8, 0xC, 0x10. Flushes stay 0.
- At pc=0x10: branch_valid=1, conditional_s=1, branch_target=0x40 -> next cycle pc=0x40, flush_ifid/idex high for 2 cycles, then pc 0x44, 0x48, taken_count=1.
- branch_valid=1, conditional_s=0, target=0x80 -> pc continues +4, no flush, taken_count unchanged.
- stall=1 for 3 cycles with jump_valid=1, jump_target=0x100 in the first stalled cycle -> pc holds and redirect_busy=1. First unstalled cycle: pc=0x100 next edge, 2 flush cycles.
- req during FLUSH (branch_target=0x200, conditional_s=1) -> ignored, pc continues from the redirect target.
- jump_target=0x123 -> pc=0x120, misalign_err single pulse. Separately, pc=0xFFFF_FFFC free-running -> wraps to 0x0. Assert rst_n=0 mid-FLUSH -> pc=0x0, flushes drop immediately.
